// File: rtl/seq_ones_counter.sv
// Multi-cycle population counter: counts the ones of a WIDTH-bit word three bits per clock
// using a parity/majority ones-count cell. Results go out over valid/ready and can feed a saturating total.
module seq_ones_counter #(
    parameter int WIDTH = 12,
    parameter int ACC_W = 16,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_acc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] out_count,
    output logic             out_parity,
    input  logic             acc_clear,
    output logic [ACC_W-1:0] acc_total,
    output logic             acc_sat
);

    localparam int NG    = (WIDTH + 2) / 3;
    localparam int PW    = 3 * NG;
    localparam int IDX_W = (NG > 1) ? $clog2(NG) : 1;
    localparam logic [ACC_W-1:0] ACC_MAX = '1;

    typedef enum logic [1:0] {
        IDLE,
        COUNT,
        DONE
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [PW-1:0]    shreg;
    logic [IDX_W-1:0] idx;
    logic [CNT_W-1:0] count;
    logic             acc_pend;
    logic [ACC_W-1:0] total;
    logic             sat;

    logic             bit_a;
    logic             bit_b;
    logic             bit_c;
    logic             cell_sum;
    logic             cell_carry;
    logic [1:0]       cell_cnt;
    logic             last_group;
    logic [ACC_W:0]   acc_sum;

    // Ones-count cell over the current low group: {carry,sum} is the count of 0..3 ones.
    assign bit_a      = shreg[0];
    assign bit_b      = shreg[1];
    assign bit_c      = shreg[2];
    assign cell_sum   = bit_a ^ bit_b ^ bit_c;
    assign cell_carry = (bit_a & bit_b) | (bit_a & bit_c) | (bit_b & bit_c);
    assign cell_cnt   = {cell_carry, cell_sum};

    assign last_group = (idx == IDX_W'(NG - 1));
    assign acc_sum    = {1'b0, total} + (ACC_W + 1)'(count);

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = rst_n;
                if (in_valid) begin
                    state_next = COUNT;
                end
            end
            COUNT: begin
                if (last_group) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid = rst_n;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // The accumulator update is independent of the word datapath; a coincident clear wins.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shreg    <= '0;
            idx      <= '0;
            count    <= '0;
            acc_pend <= 1'b0;
            total    <= '0;
            sat      <= 1'b0;
        end else begin
            if (state == IDLE && in_valid) begin
                shreg    <= PW'(in_data);
                acc_pend <= in_acc;
                count    <= '0;
                idx      <= '0;
            end else if (state == COUNT) begin
                count <= count + CNT_W'(cell_cnt);
                shreg <= shreg >> 3;
                idx   <= idx + IDX_W'(1);
            end

            if (acc_clear) begin
                total <= '0;
                sat   <= 1'b0;
            end else if (state == DONE && out_ready && acc_pend) begin
                if (sat || acc_sum[ACC_W]) begin
                    total <= ACC_MAX;
                    sat   <= 1'b1;
                end else begin
                    total <= acc_sum[ACC_W-1:0];
                end
            end
        end
    end

    assign out_count  = count;
    assign out_parity = count[0];
    assign acc_total  = total;
    assign acc_sat    = sat;

endmodule
